// File: rtl/pe_cpaf_pkg.sv
// Shared constants and helpers for the CPAF drain: carry-save field layout,
// saturation bounds and the shift clamp limit.
package pe_cpaf_pkg;

  localparam int unsigned ACC_W_DEF = 68;
  localparam int unsigned OUT_W_DEF = 8;
  localparam int unsigned SHIFT_W   = 6;

  // in_c layout: sum in the upper half, carry in the lower half
  localparam int unsigned CARRY_LSB = 0;

  function automatic int unsigned sum_lsb(int unsigned acc_w);
    return acc_w;
  endfunction

  function automatic int sat_max(int unsigned out_w);
    return (1 << (out_w - 1)) - 1;
  endfunction

  function automatic int sat_min(int unsigned out_w);
    return -(1 << (out_w - 1));
  endfunction

  function automatic int unsigned shift_lim(int unsigned acc_w);
    return acc_w - 1;
  endfunction

endpackage

// File: rtl/pe_cpaf_drain_fifo.sv
// Show-ahead FIFO for drain results; output holds the last popped entry when empty.
// Pointers carry an extra wrap bit so full and empty are distinguishable.
module pe_cpaf_drain_fifo #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic             drop
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wptr_q, rptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] hold_q;
  logic             do_push, do_pop;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A concurrent pop frees the slot, so a push into a full FIFO still lands
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;
  assign rdata   = empty ? hold_q : mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      hold_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop) begin
        rptr_q <= rptr_q + 1'b1;
        hold_q <= mem_q[rptr_q[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/pe_cpaf_drain.sv
// South-edge drain for one CPAF PE column: resolve carry-save, round-shift, saturate, buffer.
// Optional PE_CPAF_DRAIN_SATCNT_EN adds a saturating sat_count of clipped results.
module pe_cpaf_drain
  import pe_cpaf_pkg::*;
#(
  parameter int unsigned ACC_W = ACC_W_DEF,
  parameter int unsigned OUT_W = OUT_W_DEF,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned ROWS  = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [2*ACC_W-1:0] in_c,
  input  logic               in_valid,
  input  logic               in_propagate,
  input  logic [SHIFT_W-1:0] in_shift,
  output logic [OUT_W-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last,
  output logic               overflow_err,
  output logic               tile_abort
`ifdef PE_CPAF_DRAIN_SATCNT_EN
  ,
  output logic [15:0]        sat_count
`endif
);

  localparam int unsigned SUM_LSB   = sum_lsb(ACC_W);
  localparam int unsigned SHIFT_LIM = shift_lim(ACC_W);
  localparam int unsigned SW        = $clog2(ACC_W);
  localparam int unsigned RW        = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic signed [ACC_W:0] MAXV = (ACC_W + 1)'(sat_max(OUT_W));
  localparam logic signed [ACC_W:0] MINV = (ACC_W + 1)'(sat_min(OUT_W));

  // Tile tracking at the input
  logic [RW-1:0] row_q, row_d, row_eff;
  logic          prop_q, prop_d;
  logic          new_tile, beat_last, abort_d;

  always_comb begin
    new_tile  = (in_propagate != prop_q);
    row_eff   = new_tile ? '0 : row_q;
    beat_last = (row_eff == RW'(ROWS - 1));
    row_d     = row_q;
    prop_d    = prop_q;
    abort_d   = 1'b0;
    if (in_valid) begin
      row_d   = beat_last ? '0 : row_eff + 1'b1;
      prop_d  = in_propagate;
      abort_d = new_tile && (row_q != '0);
    end
  end

  // Stage 1: carry-save resolve
  logic               s1_valid_q, s1_last_q, abort_q;
  logic [ACC_W-1:0]   s1_acc_q;
  logic [SHIFT_W-1:0] s1_shift_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      row_q      <= '0;
      prop_q     <= 1'b0;
      abort_q    <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_acc_q   <= '0;
      s1_shift_q <= '0;
    end else begin
      row_q      <= row_d;
      prop_q     <= prop_d;
      abort_q    <= abort_d;
      s1_valid_q <= in_valid;
      s1_last_q  <= in_valid && beat_last;
      s1_acc_q   <= in_c[SUM_LSB +: ACC_W] + in_c[CARRY_LSB +: ACC_W];
      s1_shift_q <= in_shift;
    end
  end

  assign tile_abort = abort_q;

  // Stage 2: round half-up then arithmetic shift, one guard bit so the bias cannot wrap
  logic [SW-1:0]         sh;
  logic signed [ACC_W:0] ext, bias, rounded;

  always_comb begin
    if (32'(s1_shift_q) > SHIFT_LIM) sh = SW'(SHIFT_LIM);
    else                             sh = SW'(s1_shift_q);
    ext     = $signed({s1_acc_q[ACC_W-1], s1_acc_q});
    bias    = (sh == '0) ? '0 : ((ACC_W + 1)'(1) << (sh - 1'b1));
    rounded = (ext + bias) >>> sh;
  end

  logic                  s2_valid_q, s2_last_q;
  logic signed [ACC_W:0] s2_val_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s2_valid_q <= 1'b0;
      s2_last_q  <= 1'b0;
      s2_val_q   <= '0;
    end else begin
      s2_valid_q <= s1_valid_q;
      s2_last_q  <= s1_last_q;
      s2_val_q   <= rounded;
    end
  end

  // Stage 3: saturate
  logic [OUT_W-1:0] sat_data;
  logic             sat_clip;

  always_comb begin
    sat_clip = 1'b1;
    if (s2_val_q > MAXV) begin
      sat_data = MAXV[OUT_W-1:0];
    end else if (s2_val_q < MINV) begin
      sat_data = MINV[OUT_W-1:0];
    end else begin
      sat_data = s2_val_q[OUT_W-1:0];
      sat_clip = 1'b0;
    end
  end

  logic             s3_valid_q, s3_last_q;
  logic [OUT_W-1:0] s3_data_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s3_valid_q <= 1'b0;
      s3_last_q  <= 1'b0;
      s3_data_q  <= '0;
    end else begin
      s3_valid_q <= s2_valid_q;
      s3_last_q  <= s2_last_q;
      s3_data_q  <= sat_data;
    end
  end

`ifdef PE_CPAF_DRAIN_SATCNT_EN
  logic [15:0] sat_cnt_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sat_cnt_q <= '0;
    end else if (s2_valid_q && sat_clip && (sat_cnt_q != 16'hFFFF)) begin
      sat_cnt_q <= sat_cnt_q + 16'd1;
    end
  end

  assign sat_count = sat_cnt_q;
`else
  logic unused_clip;
  assign unused_clip = sat_clip;
`endif

  // Output buffer; the mesh cannot stall, so a full FIFO drops and flags
  logic fifo_empty, fifo_drop, unused_full;
  logic overflow_q;

  pe_cpaf_drain_fifo #(
    .WIDTH(OUT_W + 1),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (CLK),
    .rst  (RST),
    .push (s3_valid_q),
    .wdata({s3_last_q, s3_data_q}),
    .pop  (out_ready),
    .rdata({out_last, out_data}),
    .full (unused_full),
    .empty(fifo_empty),
    .drop (fifo_drop)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)            overflow_q <= 1'b0;
    else if (fifo_drop) overflow_q <= 1'b1;
  end

  assign out_valid    = !fifo_empty;
  assign overflow_err = overflow_q;

endmodule
